// File: rtl/icache_ctrl_if.sv
// Refill bus between the instruction cache and main memory.
// The cache issues one word request at a time and memory returns data together with the ack.
interface icache_ctrl_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
  modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);
endinterface

// File: rtl/icache_ctrl.sv
// Direct-mapped, read-only instruction cache for the Fetch stage.
// Hits are served combinationally. A miss refills one line word by word, and memValid1 stalls the pipeline during the refill.
module icache_ctrl #(
  parameter int LINES = 16,
  parameter int WORDS = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   addr_F,
  input  logic          rden_F,
  input  logic          invalidate,
  output logic [31:0]   inst_F,
  output logic          memValid1,
  icache_ctrl_if.master mem
);

  localparam int WB  = $clog2(WORDS);
  localparam int OB  = WB + 2;
  localparam int IB  = $clog2(LINES);
  localparam int TW  = 32 - OB - IB;
  localparam int LBW = 32 - OB;

  typedef enum logic {LOOKUP, REFILL} state_e;

  state_e             state_q, state_d;
  logic [WB-1:0]      cnt_q, cnt_d;
  logic [LBW-1:0]     line_base_q, line_base_d;
  logic [LINES-1:0]   valid_q, valid_d;
  logic               inv_pend_q, inv_pend_d;

  logic [31:0]        data_mem [LINES][WORDS];
  logic [TW-1:0]      tag_mem  [LINES];

  logic [WB-1:0]      offset;
  logic [IB-1:0]      index;
  logic [TW-1:0]      tag;
  logic [IB-1:0]      rindex;
  logic [TW-1:0]      rtag;
  logic               hit;
  logic               data_we;
  logic               tag_we;
  logic               mem_req;
  logic [31:0]        mem_addr;
  logic               unused_addr_bits;

  assign offset = addr_F[OB-1:2];
  assign index  = addr_F[OB+IB-1:OB];
  assign tag    = addr_F[31:OB+IB];
  assign rindex = line_base_q[IB-1:0];
  assign rtag   = line_base_q[LBW-1:IB];
  assign hit    = valid_q[index] && (tag_mem[index] == tag);
  assign inst_F = data_mem[index][offset];
  assign unused_addr_bits = ^addr_F[1:0];

  assign mem.mem_req  = mem_req;
  assign mem.mem_addr = mem_addr;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    line_base_d = line_base_q;
    valid_d     = valid_q;
    inv_pend_d  = inv_pend_q;
    memValid1   = 1'b1;
    mem_req     = 1'b0;
    mem_addr    = '0;
    data_we     = 1'b0;
    tag_we      = 1'b0;

    case (state_q)
      LOOKUP: begin
        memValid1 = ~rden_F | hit;
        // The lookup above still sees the old valid bits; the clear lands at the edge.
        if (invalidate) valid_d = '0;
        if (rden_F && !hit) begin
          line_base_d = addr_F[31:OB];
          cnt_d       = '0;
          state_d     = REFILL;
        end
      end
      REFILL: begin
        memValid1 = 1'b0;
        mem_req   = 1'b1;
        mem_addr  = {line_base_q, cnt_q, 2'b00};
        if (invalidate) inv_pend_d = 1'b1;
        if (mem.mem_ack) begin
          data_we = 1'b1;
          cnt_d   = cnt_q + WB'(1);
          if (cnt_q == WB'(WORDS - 1)) begin
            tag_we     = 1'b1;
            state_d    = LOOKUP;
            inv_pend_d = 1'b0;
            if (inv_pend_q || invalidate) valid_d = '0;
            else                          valid_d[rindex] = 1'b1;
          end
        end
      end
      default: state_d = LOOKUP;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= LOOKUP;
      cnt_q       <= '0;
      line_base_q <= '0;
      valid_q     <= '0;
      inv_pend_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      line_base_q <= line_base_d;
      valid_q     <= valid_d;
      inv_pend_q  <= inv_pend_d;
    end
  end

  // NOTE: tag and data arrays are not reset; the valid vector alone decides whether their contents count.
  always_ff @(posedge clk) begin
    if (data_we) data_mem[rindex][cnt_q] <= mem.mem_rdata;
    if (tag_we)  tag_mem[rindex]         <= rtag;
  end

endmodule
